perf_monitor_reader: RTL and testbench

Register-bus initiator that drains latency samples from the performance monitor's PERF_DATA register. It polls the register; data[30:0] holds a 31-bit latency and bit 31 (v) marks it valid. On each valid sample it clears v by writing 0, forwards the sample on a valid/ready stream, and keeps running statistics (count, sum, min, max). It sits beside the monitor on the config register bus, in place of software, for on-chip self-profiling.

---
 rtl/perf_monitor_reader.sv | 199 +++++++++++++++++++
 tb/tb_perf_monitor_reader.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor_reader.sv
// perf_monitor_reader: register-bus initiator that polls PERF_DATA, clears
// each valid latency sample, forwards it on a valid/ready stream and keeps
// saturating count/sum/min/max statistics plus a bus-error counter.
module perf_monitor_reader #(
  parameter logic [2:0]  PERF_DATA_ADDR = 3'h0,
  parameter int unsigned POLL_INTERVAL  = 16,
  parameter int unsigned SUM_WIDTH      = 48
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 stats_clear_i,
  output logic [2:0]           reg_addr_o,
  output logic                 reg_write_o,
  output logic [31:0]          reg_wdata_o,
  output logic [3:0]           reg_wstrb_o,
  output logic                 reg_valid_o,
  input  logic [31:0]          reg_rdata_i,
  input  logic                 reg_error_i,
  input  logic                 reg_ready_i,
  output logic [30:0]          sample_o,
  output logic                 sample_valid_o,
  input  logic                 sample_ready_i,
  output logic [31:0]          count_o,
  output logic [SUM_WIDTH-1:0] sum_o,
  output logic [30:0]          min_o,
  output logic [30:0]          max_o,
  output logic [15:0]          err_count_o
);

  localparam int unsigned TW = (POLL_INTERVAL < 2) ? 1 : $clog2(POLL_INTERVAL + 1);
  // Accumulator scratch width: one carry bit above the wider of sum and sample.
  localparam int unsigned AW = ((SUM_WIDTH > 31) ? SUM_WIDTH : 31) + 1;
  localparam logic [TW-1:0] POLL_LOAD = TW'(POLL_INTERVAL);

  typedef enum logic [1:0] {S_WAIT, S_RD, S_WR, S_OUT} state_e;

  state_e               state_q;
  logic [TW-1:0]        timer_q;
  logic [2:0]           reg_addr_q;
  logic                 reg_write_q;
  logic [31:0]          reg_wdata_q;
  logic [3:0]           reg_wstrb_q;
  logic                 reg_valid_q;
  logic [30:0]          sample_q;
  logic                 sample_valid_q;

  logic [31:0]          count_q, count_d;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [30:0]          min_q, min_d;
  logic [30:0]          max_q, max_d;
  logic [15:0]          err_q, err_d;
  logic [AW-1:0]        sum_ext;

  logic bus_hs;
  logic smp_hs;

  assign bus_hs = reg_valid_q & reg_ready_i;
  assign smp_hs = sample_valid_q & sample_ready_i;

  // Poll/clear/forward sequencer with registered bus and stream outputs.
  // A read that returns a valid sample keeps reg_valid high and retargets the
  // request as the clearing write, so a burst drains at one sample per 3 cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_WAIT;
      timer_q        <= '0;
      reg_addr_q     <= '0;
      reg_write_q    <= 1'b0;
      reg_wdata_q    <= '0;
      reg_wstrb_q    <= '0;
      reg_valid_q    <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
          end else if (enable_i) begin
            state_q     <= S_RD;
            reg_valid_q <= 1'b1;
            reg_addr_q  <= PERF_DATA_ADDR;
            reg_write_q <= 1'b0;
            reg_wdata_q <= '0;
            reg_wstrb_q <= '0;
          end
        end
        S_RD: begin
          if (bus_hs) begin
            if (reg_error_i || !reg_rdata_i[31]) begin
              state_q     <= S_WAIT;
              timer_q     <= POLL_LOAD;
              reg_valid_q <= 1'b0;
              reg_addr_q  <= '0;
            end else begin
              state_q     <= S_WR;
              sample_q    <= reg_rdata_i[30:0];
              reg_write_q <= 1'b1;
              reg_wdata_q <= '0;
              reg_wstrb_q <= '1;
            end
          end
        end
        S_WR: begin
          if (bus_hs) begin
            reg_valid_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_write_q <= 1'b0;
            reg_wdata_q <= '0;
            reg_wstrb_q <= '0;
            if (reg_error_i) begin
              state_q <= S_WAIT;
              timer_q <= POLL_LOAD;
            end else begin
              state_q        <= S_OUT;
              sample_valid_q <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (smp_hs) begin
            sample_valid_q <= 1'b0;
            if (enable_i) begin
              state_q     <= S_RD;
              reg_valid_q <= 1'b1;
              reg_addr_q  <= PERF_DATA_ADDR;
              reg_write_q <= 1'b0;
              reg_wdata_q <= '0;
              reg_wstrb_q <= '0;
            end else begin
              state_q <= S_WAIT;
              timer_q <= '0;
            end
          end
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  // Next-state statistics; a clear overrides any coincident sample or error.
  always_comb begin
    count_d = count_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
    err_d   = err_q;
    sum_ext = '0;
    if (stats_clear_i) begin
      count_d = '0;
      sum_d   = '0;
      min_d   = '1;
      max_d   = '0;
      err_d   = '0;
    end else begin
      if (smp_hs) begin
        if (count_q != '1) count_d = count_q + 32'd1;
        sum_ext = AW'(sum_q) + AW'(sample_q);
        if (|sum_ext[AW-1:SUM_WIDTH]) sum_d = '1;
        else                          sum_d = sum_ext[SUM_WIDTH-1:0];
        if (sample_q < min_q) min_d = sample_q;
        if (sample_q > max_q) max_d = sample_q;
      end
      if (bus_hs && reg_error_i && (err_q != '1)) err_d = err_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      sum_q   <= '0;
      min_q   <= '1;
      max_q   <= '0;
      err_q   <= '0;
    end else begin
      count_q <= count_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      max_q   <= max_d;
      err_q   <= err_d;
    end
  end

  assign reg_addr_o     = reg_addr_q;
  assign reg_write_o    = reg_write_q;
  assign reg_wdata_o    = reg_wdata_q;
  assign reg_wstrb_o    = reg_wstrb_q;
  assign reg_valid_o    = reg_valid_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;
  assign count_o        = count_q;
  assign sum_o          = sum_q;
  assign min_o          = min_q;
  assign max_o          = max_q;
  assign err_count_o    = err_q;

endmodule

// File: tb/tb_perf_monitor_reader.sv
// Bench for perf_monitor_reader: a PERF_DATA register model answers the bus,
// a sink consumes samples against a scoreboard queue, and a small statistics
// model tracks count/sum/min/max/errors. A second instance with an 8-bit
// accumulator shares all inputs to exercise sum saturation.
module tb_perf_monitor_reader;

  localparam logic [2:0]  ADDR = 3'h5;
  localparam int unsigned POLL = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic        stats_clear_i = 1'b0;
  logic [2:0]  reg_addr_o;
  logic        reg_write_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_wstrb_o;
  logic        reg_valid_o;
  logic [31:0] reg_rdata_i = '0;
  logic        reg_error_i = 1'b0;
  logic        reg_ready_i = 1'b0;
  logic [30:0] sample_o;
  logic        sample_valid_o;
  logic        sample_ready_i = 1'b0;
  logic [31:0] count_o;
  logic [47:0] sum_o;
  logic [30:0] min_o, max_o;
  logic [15:0] err_count_o;

  logic [2:0]  b_addr;
  logic        b_write;
  logic [31:0] b_wdata;
  logic [3:0]  b_wstrb;
  logic        b_valid;
  logic [30:0] b_sample;
  logic        b_svalid;
  logic [31:0] b_count;
  logic [7:0]  b_sum;
  logic [30:0] b_min, b_max;
  logic [15:0] b_err;

  always #5 clk_i = ~clk_i;

  perf_monitor_reader #(.PERF_DATA_ADDR(ADDR), .POLL_INTERVAL(POLL), .SUM_WIDTH(48)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .stats_clear_i(stats_clear_i),
    .reg_addr_o(reg_addr_o), .reg_write_o(reg_write_o), .reg_wdata_o(reg_wdata_o),
    .reg_wstrb_o(reg_wstrb_o), .reg_valid_o(reg_valid_o), .reg_rdata_i(reg_rdata_i),
    .reg_error_i(reg_error_i), .reg_ready_i(reg_ready_i), .sample_o(sample_o),
    .sample_valid_o(sample_valid_o), .sample_ready_i(sample_ready_i), .count_o(count_o),
    .sum_o(sum_o), .min_o(min_o), .max_o(max_o), .err_count_o(err_count_o)
  );

  perf_monitor_reader #(.PERF_DATA_ADDR(ADDR), .POLL_INTERVAL(POLL), .SUM_WIDTH(8)) dut8 (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .stats_clear_i(stats_clear_i),
    .reg_addr_o(b_addr), .reg_write_o(b_write), .reg_wdata_o(b_wdata),
    .reg_wstrb_o(b_wstrb), .reg_valid_o(b_valid), .reg_rdata_i(reg_rdata_i),
    .reg_error_i(reg_error_i), .reg_ready_i(reg_ready_i), .sample_o(b_sample),
    .sample_valid_o(b_svalid), .sample_ready_i(sample_ready_i), .count_o(b_count),
    .sum_o(b_sum), .min_o(b_min), .max_o(b_max), .err_count_o(b_err)
  );

  int total = 0;
  int bad = 0;

  // PERF_DATA contents waiting to be drained, and the scoreboard of samples
  // the sink expects, in order.
  logic [30:0] perf[$];
  logic [30:0] exp_q[$];
  int          hs_cyc[$];

  logic [31:0] m_count;
  logic [47:0] m_sum;
  logic [7:0]  m_sum8;
  logic [30:0] m_min, m_max;
  logic [15:0] m_err;

  int n_rd = 0, n_wr = 0, n_smp = 0, cyc = 0, sv_cycles = 0;
  int rd_stall = 0, wr_stall = 0, sink_stall = 0;
  bit err_rd_arm = 0, err_wr_arm = 0, clear_now = 0, clear_on_hs = 0;
  bit rd_empty_hs = 0, wr_err_hs = 0, req_open = 0;
  logic [39:0] cap_req;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset_stats();
    m_count = '0; m_sum = '0; m_sum8 = '0; m_min = '1; m_max = '0; m_err = '0;
  endtask

  task automatic model_accumulate(input logic [30:0] s);
    longint t;
    if (m_count != 32'hFFFF_FFFF) m_count++;
    m_sum = m_sum + 48'(s);
    t = longint'(m_sum8) + longint'(s);
    m_sum8 = (t > 255) ? 8'hFF : 8'(t);
    if (s < m_min) m_min = s;
    if (s > m_max) m_max = s;
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_count"}, count_o, m_count);
    chk({tag, "_sum"}, sum_o, m_sum);
    chk({tag, "_sum8"}, b_sum, m_sum8);
    chk({tag, "_min"}, min_o, m_min);
    chk({tag, "_max"}, max_o, m_max);
    chk({tag, "_err"}, err_count_o, m_err);
    chk({tag, "_b_count"}, b_count, m_count);
    chk({tag, "_b_minmax"}, {b_min, b_max, b_err}, {m_min, m_max, m_err});
  endtask

  // One clock: respond to the bus and the stream at the falling edge, update
  // the model, then return just after the rising edge.
  task automatic step();
    bit          hs;
    bit          berr;
    logic [30:0] s;
    hs = 0; berr = 0; s = '0;
    @(negedge clk_i);
    reg_ready_i = 1'b0; reg_error_i = 1'b0; reg_rdata_i = '0;
    rd_empty_hs = 0; wr_err_hs = 0;
    if (reg_valid_o) begin
      if (!req_open) begin
        req_open = 1;
        cap_req = {reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o};
      end else begin
        chk("req_stable", {reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o}, cap_req);
      end
      if (!reg_write_o && rd_stall > 0) rd_stall--;
      else if (reg_write_o && wr_stall > 0) wr_stall--;
      else begin
        reg_ready_i = 1'b1;
        req_open = 0;
        if (!reg_write_o) begin
          n_rd++;
          chk("rd_fields", {reg_addr_o, reg_wstrb_o}, {ADDR, 4'h0});
          if (err_rd_arm) begin
            err_rd_arm = 0; reg_error_i = 1'b1; berr = 1;
          end else if (perf.size() > 0) begin
            reg_rdata_i = {1'b1, perf[0]};
          end else begin
            rd_empty_hs = 1;
          end
        end else begin
          n_wr++;
          chk("wr_fields", {reg_addr_o, reg_wdata_o, reg_wstrb_o}, {ADDR, 32'h0, 4'hF});
          if (err_wr_arm) begin
            err_wr_arm = 0; reg_error_i = 1'b1; berr = 1; wr_err_hs = 1;
          end else if (perf.size() > 0) begin
            void'(perf.pop_front());
          end
        end
      end
    end else begin
      req_open = 0;
    end

    sample_ready_i = 1'b0;
    if (sample_valid_o) begin
      sv_cycles++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_sample: got %0d expected none", sample_o);
      end else if (sink_stall > 0) begin
        sink_stall--;
        chk("smp_hold", sample_o, exp_q[0]);
        chk("cnt_hold", count_o, m_count);
      end else begin
        sample_ready_i = 1'b1;
        hs = 1;
        s = exp_q.pop_front();
        chk("sample", sample_o, s);
        n_smp++;
        hs_cyc.push_back(cyc);
      end
    end

    stats_clear_i = clear_now || (clear_on_hs && hs);
    clear_now = 0;
    if (hs) clear_on_hs = 0;
    if (stats_clear_i) model_reset_stats();
    else begin
      if (hs) model_accumulate(s);
      if (berr && m_err != 16'hFFFF) m_err++;
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic run_samples(input int target, input int budget);
    int k;
    k = 0;
    while (n_smp < target && k < budget) begin step(); k++; end
    if (n_smp < target) begin
      total++; bad++;
      $display("FAIL timeout_samples: got %0d expected %0d", n_smp, target);
    end
  endtask

  task automatic quiesce();
    enable_i = 1'b0;
    for (int k = 0; k < 30; k++) step();
  endtask

  task automatic measure_gap(input string name);
    int gap;
    gap = 0;
    while (!reg_valid_o && gap < 50) begin step(); gap++; end
    chk(name, gap, POLL + 1);
  endtask

  typedef struct {
    logic [30:0] lat;
    logic [31:0] cnt;
    logic [47:0] sum;
    logic [7:0]  sum8;
    logic [30:0] mn;
    logic [30:0] mx;
  } vec_t;

  initial begin
    vec_t vt[4];
    int r0, w0, s0, k;
    vt[0] = '{31'd100,         32'd1, 48'd100,        8'd100, 31'd100, 31'd100};
    vt[1] = '{31'd0,           32'd2, 48'd100,        8'd100, 31'd0,   31'd100};
    vt[2] = '{31'h7FFF_FFFF,   32'd3, 48'd2147483747, 8'd255, 31'd0,   31'h7FFF_FFFF};
    vt[3] = '{31'd5,           32'd4, 48'd2147483752, 8'd255, 31'd0,   31'h7FFF_FFFF};
    model_reset_stats();

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_bus", {reg_valid_o, reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o}, '0);
    chk("rst_stream", {sample_valid_o, sample_o}, '0);
    chk("rst_stats", {count_o, err_count_o, max_o}, '0);
    chk("rst_sum", sum_o, '0);
    chk("rst_min", min_o, 31'h7FFF_FFFF);
    chk("rst_b", {b_valid, b_addr, b_write, b_wdata, b_wstrb, b_svalid, b_sample, b_sum}, '0);
    rst_ni = 1'b1;

    // Single samples, including the 0 and all-ones extremes
    for (int i = 0; i < 4; i++) begin
      quiesce();
      r0 = n_rd; w0 = n_wr; s0 = n_smp; sv_cycles = 0;
      perf.push_back(vt[i].lat); exp_q.push_back(vt[i].lat);
      enable_i = 1'b1;
      run_samples(s0 + 1, 60);
      chk("vec_reads", n_rd - r0, 1);
      chk("vec_writes", n_wr - w0, 1);
      chk("vec_valid_cycles", sv_cycles, 1);
      chk("vec_count", count_o, vt[i].cnt);
      chk("vec_sum", sum_o, vt[i].sum);
      chk("vec_sum8", b_sum, vt[i].sum8);
      chk("vec_min", min_o, vt[i].mn);
      chk("vec_max", max_o, vt[i].mx);
    end

    // Burst drain of three queued samples, then an empty poll and the timer gap
    quiesce();
    clear_now = 1; step();
    chk("clr_count", count_o, 0);
    chk("clr_min", min_o, 31'h7FFF_FFFF);
    hs_cyc.delete(); s0 = n_smp;
    perf.push_back(31'd10); perf.push_back(31'd5); perf.push_back(31'd20);
    exp_q.push_back(31'd10); exp_q.push_back(31'd5); exp_q.push_back(31'd20);
    enable_i = 1'b1;
    run_samples(s0 + 3, 80);
    if (hs_cyc.size() >= 3) begin
      chk("burst_gap1", hs_cyc[1] - hs_cyc[0], 3);
      chk("burst_gap2", hs_cyc[2] - hs_cyc[1], 3);
    end else begin
      total++; bad++;
      $display("FAIL burst_hs: got %0d expected 3", hs_cyc.size());
    end
    chk("burst_stats", {count_o, min_o, max_o}, {32'd3, 31'd5, 31'd20});
    chk("burst_sum", sum_o, 48'd35);
    k = 0;
    while (!rd_empty_hs && k < 10) begin step(); k++; end
    chk("burst_empty_read", rd_empty_hs, 1);
    measure_gap("poll_gap");

    // Bus stall on the read and sink stall on the output
    quiesce();
    r0 = n_rd; s0 = n_smp; sv_cycles = 0;
    perf.push_back(31'd77); exp_q.push_back(31'd77);
    rd_stall = 7; sink_stall = 5; enable_i = 1'b1;
    run_samples(s0 + 1, 60);
    enable_i = 1'b0;
    chk("stall_reads", n_rd - r0, 1);
    chk("stall_valid_cycles", sv_cycles, 6);
    check_stats("stall");

    // Error on read, then error on the clearing write
    quiesce();
    s0 = n_smp;
    perf.push_back(31'd42); exp_q.push_back(31'd42);
    err_rd_arm = 1; err_wr_arm = 1; enable_i = 1'b1;
    k = 0;
    while (!wr_err_hs && k < 60) begin step(); k++; end
    chk("err_wr_seen", wr_err_hs, 1);
    chk("err_no_sample", n_smp - s0, 0);
    chk("err_count", err_count_o, 16'd2);
    chk("err_stats_kept", count_o, 32'd4);
    measure_gap("err_poll_gap");
    run_samples(s0 + 1, 60);
    enable_i = 1'b0;
    check_stats("err");

    // 8-bit accumulator saturation and clear coincident with a handshake
    quiesce();
    clear_now = 1; step();
    s0 = n_smp;
    perf.push_back(31'd200); perf.push_back(31'd100);
    exp_q.push_back(31'd200); exp_q.push_back(31'd100);
    enable_i = 1'b1;
    run_samples(s0 + 2, 60);
    chk("sat_sum8", b_sum, 8'd255);
    chk("sat_sum48", sum_o, 48'd300);
    chk("sat_count", count_o, 32'd2);
    quiesce();
    perf.push_back(31'd9); exp_q.push_back(31'd9);
    clear_on_hs = 1; enable_i = 1'b1;
    run_samples(s0 + 3, 60);
    chk("clrhs_count", count_o, 0);
    chk("clrhs_min", min_o, 31'h7FFF_FFFF);
    chk("clrhs_sum", {sum_o, b_sum, max_o}, '0);
    check_stats("clrhs");

    // Asynchronous reset while a clearing write is stalled on the bus
    quiesce();
    s0 = n_smp;
    perf.push_back(31'd33); perf.push_back(31'd55);
    exp_q.push_back(31'd33); exp_q.push_back(31'd55);
    enable_i = 1'b1;
    run_samples(s0 + 1, 60);
    wr_stall = 20;
    k = 0;
    while (!(reg_valid_o && reg_write_o) && k < 20) begin step(); k++; end
    step(); step();
    chk("prerst_wr_pending", {reg_valid_o, reg_write_o}, 2'b11);
    #1 rst_ni = 1'b0;
    #1;
    chk("arst_bus", {reg_valid_o, reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o}, '0);
    chk("arst_stream", {sample_valid_o, sample_o}, '0);
    chk("arst_stats", {count_o, err_count_o, max_o, b_sum}, '0);
    chk("arst_sum_min", {sum_o, min_o}, {48'd0, 31'h7FFF_FFFF});
    model_reset_stats(); wr_stall = 0; req_open = 0;
    step(); step();
    chk("arst_hold", reg_valid_o, 0);
    rst_ni = 1'b1;
    step();
    chk("post_rst_read", {reg_valid_o, reg_write_o}, 2'b10);
    run_samples(s0 + 2, 60);
    quiesce();
    chk("scoreboard_empty", exp_q.size(), 0);
    check_stats("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
